// File: rtl/axi_mem_pkg.sv
// Shared response/burst codes and FSM state types for the HP0 stand-in memory responder.
// Defining AXI_MEM_LAT_EN adds the R_WAIT state used for the first-beat read latency.
package axi_mem_pkg;

   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;
   localparam logic [1:0] INCR    = 2'b01;
   localparam logic [2:0] SIZE_64 = 3'b011;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

`ifdef AXI_MEM_LAT_EN
   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_FETCH,
      R_DATA
   } r_state_e;
`else
   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_DATA
   } r_state_e;
`endif

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port 64-bit RAM: one byte-enabled write port, one registered read port.
module axi_mem_ram #(
   parameter int ADDR_W = 16
) (
   input  logic              host_clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [63:0]       rdata
);

   // NOTE: the array has no reset; contents are meant to survive a reset, and clearing
   // every word would need a multi-cycle sweep the system never asked for.
   logic [63:0] mem [0:(1 << ADDR_W) - 1];

   // NOTE: non-blocking writes are what make a same-cycle read of the same word return
   // the old data; a blocking write here would leak the new word into rdata.
   always_ff @(posedge host_clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_hp_mem_responder.sv
// AXI slave backed by on-chip RAM that stands in for the Zynq HP0 port behind the memory bridge.
// Define AXI_MEM_LAT_EN to delay the first read beat by READ_LATENCY extra cycles.
module axi_hp_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int          ID_W           = 6,
   parameter int          MEM_WORDS_LOG2 = 16,
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          READ_LATENCY   = 4
) (
   input  logic            host_clk,
   input  logic            reset,
   input  logic [ID_W-1:0] s_awid,
   input  logic [31:0]     s_awaddr,
   input  logic [7:0]      s_awlen,
   input  logic [2:0]      s_awsize,
   input  logic [1:0]      s_awburst,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [63:0]     s_wdata,
   input  logic [7:0]      s_wstrb,
   input  logic            s_wlast,
   input  logic            s_wvalid,
   output logic            s_wready,
   output logic [ID_W-1:0] s_bid,
   output logic [1:0]      s_bresp,
   output logic            s_bvalid,
   input  logic            s_bready,
   input  logic [ID_W-1:0] s_arid,
   input  logic [31:0]     s_araddr,
   input  logic [7:0]      s_arlen,
   input  logic [2:0]      s_arsize,
   input  logic [1:0]      s_arburst,
   input  logic            s_arvalid,
   output logic            s_arready,
   output logic [ID_W-1:0] s_rid,
   output logic [63:0]     s_rdata,
   output logic [1:0]      s_rresp,
   output logic            s_rlast,
   output logic            s_rvalid,
   input  logic            s_rready
);

   localparam int AW = MEM_WORDS_LOG2;

   // ---------------- write channel ----------------
   w_state_e        w_state, w_state_nxt;
   logic [ID_W-1:0] w_id;
   logic [AW-1:0]   w_idx;
   logic [7:0]      w_len, w_beat;
   logic            w_err, w_oow;
   logic            awready_c, wready_c, bvalid_c;
   logic            aw_hs, w_hs, aw_in_win;

   assign aw_in_win = (s_awaddr[31:AW+3] == BASE_ADDR[31:AW+3]);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = w_state;
      awready_c   = 1'b0;
      wready_c    = 1'b0;
      bvalid_c    = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            awready_c = 1'b1;
            if (s_awvalid) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            wready_c = 1'b1;
            if (s_wvalid && (w_beat == w_len)) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid_c = 1'b1;
            if (s_bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge host_clk) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_err   <= 1'b0;
         w_oow   <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         if (aw_hs) begin
            w_id   <= s_awid;
            w_idx  <= s_awaddr[AW+2:3];
            w_len  <= s_awlen;
            w_beat <= '0;
            w_oow  <= !aw_in_win;
            w_err  <= !aw_in_win || (s_awsize != SIZE_64);
         end
         if (w_hs) begin
            w_idx  <= w_idx + 1'b1;
            w_beat <= w_beat + 1'b1;
            // Termination is by beat count; a misplaced wlast only poisons the response.
            if (s_wlast != (w_beat == w_len)) w_err <= 1'b1;
         end
      end
   end

   assign s_awready = awready_c && !reset;
   assign s_wready  = wready_c && !reset;
   assign s_bvalid  = bvalid_c && !reset;
   assign s_bid     = reset ? '0 : w_id;
   assign s_bresp   = (reset || !w_err) ? OKAY : SLVERR;
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid && s_wready;

   // ---------------- read channel ----------------
   r_state_e        r_state, r_state_nxt;
   logic [ID_W-1:0] r_id;
   logic [AW-1:0]   r_idx;
   logic [7:0]      r_len, r_beat;
   logic            r_err, r_oow;
   logic            arready_c, rvalid_c, ram_re;
   logic            ar_hs, r_hs, ar_in_win, r_is_last;
   logic [63:0]     ram_rdata;
`ifdef AXI_MEM_LAT_EN
   logic [15:0]     r_cnt;
`endif

   assign ar_in_win = (s_araddr[31:AW+3] == BASE_ADDR[31:AW+3]);
   assign r_is_last = (r_beat == r_len);

   always_comb begin
      r_state_nxt = r_state;
      arready_c   = 1'b0;
      rvalid_c    = 1'b0;
      ram_re      = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            arready_c = 1'b1;
`ifdef AXI_MEM_LAT_EN
            if (s_arvalid) r_state_nxt = (READ_LATENCY > 0) ? R_WAIT : R_FETCH;
`else
            if (s_arvalid) r_state_nxt = R_FETCH;
`endif
         end
`ifdef AXI_MEM_LAT_EN
         R_WAIT: begin
            if (r_cnt == '0) r_state_nxt = R_FETCH;
         end
`endif
         R_FETCH: begin
            ram_re      = 1'b1;
            r_state_nxt = R_DATA;
         end
         R_DATA: begin
            rvalid_c = 1'b1;
            if (s_rready) r_state_nxt = r_is_last ? R_IDLE : R_FETCH;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge host_clk) begin
      if (reset) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
         r_oow   <= 1'b0;
`ifdef AXI_MEM_LAT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= r_state_nxt;
         if (ar_hs) begin
            r_id   <= s_arid;
            r_idx  <= s_araddr[AW+2:3];
            r_len  <= s_arlen;
            r_beat <= '0;
            r_oow  <= !ar_in_win;
            r_err  <= !ar_in_win || (s_arsize != SIZE_64);
`ifdef AXI_MEM_LAT_EN
            r_cnt  <= 16'(READ_LATENCY - 1);
`endif
         end
`ifdef AXI_MEM_LAT_EN
         if (r_state == R_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
`endif
         if (r_hs && !r_is_last) begin
            r_idx  <= r_idx + 1'b1;
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // rdata comes straight off the RAM output register, which only reloads in R_FETCH,
   // so it stays put for as long as R_DATA waits on rready.
   assign s_arready = arready_c && !reset;
   assign s_rvalid  = rvalid_c && !reset;
   assign s_rlast   = s_rvalid && r_is_last;
   assign s_rid     = reset ? '0 : r_id;
   assign s_rresp   = (reset || !r_err) ? OKAY : SLVERR;
   assign s_rdata   = (reset || r_oow) ? '0 : ram_rdata;
   assign ar_hs     = s_arvalid && s_arready;
   assign r_hs      = s_rvalid && s_rready;

   axi_mem_ram #(
      .ADDR_W (AW)
   ) u_ram (
      .host_clk (host_clk),
      .we       (w_hs && !w_oow),
      .waddr    (w_idx),
      .wdata    (s_wdata),
      .wstrb    (s_wstrb),
      .re       (ram_re),
      .raddr    (r_idx),
      .rdata    (ram_rdata)
   );

   // Burst type is always treated as INCR, and sub-word address bits carry no meaning.
   logic unused_ok;
`ifdef AXI_MEM_LAT_EN
   assign unused_ok = ^{s_awaddr[2:0], s_araddr[2:0], s_awburst == INCR, s_arburst == INCR};
`else
   assign unused_ok = ^{s_awaddr[2:0], s_araddr[2:0], s_awburst == INCR, s_arburst == INCR,
                        READ_LATENCY[0]};
`endif

endmodule
